// File: rtl/keypad_scan_display_pkg.sv
// Shared types and width helpers for the keypad scan / digit display slice.
// Holds the scan FSM state encoding and the key-code / counter width functions.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_t;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_scan_display_digit_refresh.sv
// Time-multiplexed digit driver: cycles digit_idx every REFRESH_CYCLES and
// drives a registered one-hot enable plus code for the selected history slot.
module digit_refresh
  import keypad_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int CODE_W         = 4,
  parameter int REFRESH_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIGITS*CODE_W-1:0] i_hist,
  input  logic [DIGITS-1:0]        i_valid,
  output logic [DIGITS-1:0]        o_digit_en,
  output logic [CODE_W-1:0]        o_digit_val
);

  localparam int REF_W = cnt_width(REFRESH_CYCLES);
  localparam int IDX_W = cnt_width(DIGITS);

  logic [REF_W-1:0]  r_ref;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] r_en;
  logic [CODE_W-1:0] r_val;
  logic [DIGITS-1:0] w_onehot;

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ref <= '0;
      r_idx <= '0;
      r_en  <= '0;
      r_val <= '0;
    end else begin
      if (r_ref == REF_W'(REFRESH_CYCLES - 1)) begin
        r_ref <= '0;
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      // Unfilled slots are blanked rather than showing a stale zero.
      if (i_valid[r_idx]) begin
        r_en  <= w_onehot;
        r_val <= i_hist[int'(r_idx) * CODE_W +: CODE_W];
      end else begin
        r_en  <= '0;
        r_val <= '0;
      end
    end
  end

  assign o_digit_en  = r_en;
  assign o_digit_val = r_val;

endmodule

// File: rtl/keypad_scan_display.sv
// Keypad matrix scanner with press/release debounce, a DIGITS-deep history of
// accepted key codes, and a multiplexed display driver for that history.
module keypad_scan_display
  import keypad_pkg::*;
#(
  parameter int   ROWS            = 4,
  parameter int   COLS            = 4,
  parameter int   DIGITS          = 2,
  parameter int   SETTLE_CYCLES   = 4,
  parameter int   DEBOUNCE_CYCLES = 8,
  parameter int   REFRESH_CYCLES  = 16,
  localparam int  CODE_W          = code_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic [DIGITS-1:0] digit_en,
  output logic [CODE_W-1:0] digit_val
);

  localparam int RI_W   = cnt_width(ROWS);
  localparam int CI_W   = cnt_width(COLS);
  localparam int DW_W   = cnt_width(SETTLE_CYCLES);
  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HIST_W = DIGITS * CODE_W;

  logic [COLS-1:0]   r_col_meta;
  logic [COLS-1:0]   r_col_sync;
  kp_state_t         r_state;
  logic [RI_W-1:0]   r_row_idx;
  logic [DW_W-1:0]   r_dwell;
  logic [DB_W-1:0]   r_db;
  logic [CI_W-1:0]   r_lock_col;
  logic [HIST_W-1:0] r_hist;
  logic [DIGITS-1:0] r_valid;

  logic [RI_W-1:0]   w_next_row;
  logic [CI_W-1:0]   w_low_col;
  logic              w_lock_hi;
  logic [CODE_W-1:0] w_code;

  function automatic logic [ROWS-1:0] row_onehot(input logic [RI_W-1:0] idx);
    row_onehot      = '0;
    row_onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    w_next_row = (r_row_idx == RI_W'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
    // Walk from the top column down so the lowest set column wins.
    w_low_col = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (r_col_sync[COLS-1-i]) w_low_col = CI_W'(COLS - 1 - i);
    end
    w_lock_hi = r_col_sync[r_lock_col];
    w_code    = CODE_W'(int'(r_row_idx) * COLS + int'(r_lock_col));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col_meta <= '0;
      r_col_sync <= '0;
      r_state    <= SCAN;
      r_row_idx  <= '0;
      row        <= row_onehot('0);
      r_dwell    <= '0;
      r_db       <= '0;
      r_lock_col <= '0;
      r_hist     <= '0;
      r_valid    <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
      key_valid  <= 1'b0;
      unique case (r_state)
        SCAN: begin
          if (r_dwell == DW_W'(SETTLE_CYCLES - 1)) begin
            r_dwell <= '0;
            if (|r_col_sync) begin
              r_lock_col <= w_low_col;
              r_db       <= '0;
              r_state    <= PRESS_DB;
            end else begin
              r_row_idx <= w_next_row;
              row       <= row_onehot(w_next_row);
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        PRESS_DB: begin
          if (w_lock_hi) begin
            if (r_db == DB_W'(DEBOUNCE_CYCLES - 1)) begin
              key_valid <= 1'b1;
              key_code  <= w_code;
              // Shift by concatenation; the cast drops the oldest entry.
              r_hist    <= HIST_W'({r_hist, w_code});
              r_valid   <= DIGITS'({r_valid, 1'b1});
              r_state   <= HELD;
            end else begin
              r_db <= r_db + 1'b1;
            end
          end else begin
            r_state   <= SCAN;
            r_row_idx <= w_next_row;
            row       <= row_onehot(w_next_row);
          end
        end
        HELD: begin
          if (!w_lock_hi) begin
            r_db    <= '0;
            r_state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (w_lock_hi) begin
            r_state <= HELD;
          end else if (r_db == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state   <= SCAN;
            r_row_idx <= w_next_row;
            row       <= row_onehot(w_next_row);
          end else begin
            r_db <= r_db + 1'b1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  digit_refresh #(
    .DIGITS        (DIGITS),
    .CODE_W        (CODE_W),
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clk        (clk),
    .reset      (reset),
    .i_hist     (r_hist),
    .i_valid    (r_valid),
    .o_digit_en (digit_en),
    .o_digit_val(digit_val)
  );

endmodule

// File: tb/tb_keypad_scan_display.sv
// Scoreboard bench: key presses push expected codes, a negedge monitor pops
// them on key_valid; scan and display behaviour are checked directly.
module tb_keypad_scan_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] digit_en;
  logic [3:0] digit_val;

  logic        key_down = 1'b0;
  int unsigned key_r    = 0;
  logic [3:0]  key_mask = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_q[$];

  // Keypad model: the pressed key connects its row line to its column line.
  assign col = (key_down && row[key_r]) ? key_mask : '0;

  always #5 clk = ~clk;

  keypad_scan_display #(
    .ROWS           (4),
    .COLS           (4),
    .DIGITS         (2),
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8),
    .REFRESH_CYCLES (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_valid(key_valid),
    .key_code (key_code),
    .digit_en (digit_en),
    .digit_val(digit_val)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int unsigned e;
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key_valid: got code %0d, expected no key event", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", 32'(key_code), e);
      end
    end
  end

  task automatic wait_row(input logic [3:0] target, input int bound);
    int k = 0;
    while (row !== target && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (row !== target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_row_timeout: got row %b, expected %b", row, target);
    end
  endtask

  // Press a key just before its row is driven; returns in the first cycle
  // that row is active.
  task automatic arm(input int unsigned r, input logic [3:0] mask);
    logic [3:0] prev;
    logic [3:0] cur;
    prev = 4'b0001 << ((r + 3) % 4);
    cur  = 4'b0001 << r;
    wait_row(prev, 40);
    key_r    = r;
    key_mask = mask;
    key_down = 1'b1;
    wait_row(cur, 40);
  endtask

  task automatic disp_check(input string name, input logic [3:0] v0,
                            input logic [3:0] v1, input bit has1);
    int n0 = 0;
    int n1 = 0;
    int nz = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (digit_en == 2'b01 && digit_val == v0) n0++;
      else if (digit_en == 2'b10 && digit_val == v1) n1++;
      else if (digit_en == 2'b00 && digit_val == 4'd0) nz++;
    end
    check({name, "_digit0_cycles"}, n0, 32);
    if (has1) check({name, "_digit1_cycles"}, n1, 32);
    else      check({name, "_blank_cycles"}, nz, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int blank;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_row", row, 4'b0001);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_digit_en", digit_en, 0);
    check("rst_digit_val", digit_val, 0);
    reset = 1'b1;

    // Idle scan: each row dwells 4 cycles
    for (int i = 0; i < 20; i++) begin
      check("scan_row", row, 4'b0001 << ((i / 4) % 4));
      @(negedge clk);
    end
    check("idle_digit_en", digit_en, 0);

    // Press bounce: 5 high samples, 1 low, then high again
    arm(1, 4'b0100);
    repeat (7) @(negedge clk);
    key_down = 1'b0;
    @(negedge clk);
    key_down = 1'b1;
    repeat (5) @(negedge clk);
    check("bounce_next_row", row, 4'b0100);
    key_down = 1'b0;
    repeat (20) @(negedge clk);

    // Clean press of row 1 / col 2
    arm(1, 4'b0100);
    exp_q.push_back(6);
    repeat (20) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    disp_check("one_key", 4'd6, 4'd0, 1'b0);

    // Row 3 / col 0 shifts the history
    arm(3, 4'b0001);
    exp_q.push_back(12);
    repeat (20) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    disp_check("two_keys", 4'd12, 4'd6, 1'b1);

    // Release bounce on row 0 / col 3
    arm(0, 4'b1000);
    exp_q.push_back(3);
    repeat (20) @(negedge clk);
    key_down = 1'b0;
    repeat (3) @(negedge clk);
    key_down = 1'b1;
    repeat (2) @(negedge clk);
    check("held_through_bounce", row, 4'b0001);
    key_down = 1'b0;
    repeat (5) @(negedge clk);
    check("still_release_db", row, 4'b0001);
    wait_row(4'b0010, 40);
    repeat (10) @(negedge clk);
    disp_check("three_keys", 4'd3, 4'd12, 1'b1);

    // Reset during press debounce discards the key and the history
    arm(2, 4'b0010);
    repeat (6) @(negedge clk);
    reset    = 1'b0;
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_row", row, 4'b0001);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_code", key_code, 0);
    check("mid_rst_digit_en", digit_en, 0);
    check("mid_rst_digit_val", digit_val, 0);
    reset = 1'b1;
    blank = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (digit_en == 2'b00 && digit_val == 4'd0) blank++;
    end
    check("post_rst_blank_cycles", blank, 64);

    repeat (20) @(negedge clk);
    check("pending_key_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_display.md
# keypad_scan_display

Parametrised keypad-scan and multi-digit display core for the keypad/seven-segment designs: ROWS×COLS matrix scanning with column synchronisation, press/release debounce, a DIGITS-deep history of accepted key codes, and a time-multiplexed digit driver. It sits between the keypad pins and the seven-segment decoder. Unlike the two-digit scanner it replaces, it supports arbitrary matrix size, display depth, a one-cycle key event output, and blanking of digits not yet filled.

## Interface
- ROWS, 4, keypad rows driven (≥2)
- COLS, 4, keypad columns sensed (≥2)
- DIGITS, 2, display digits / history depth (≥1)
- SETTLE_CYCLES, 4, row dwell per scan step (≥3, covers 2-flop sync)
- DEBOUNCE_CYCLES, 8, consecutive stable cycles for press or release
- REFRESH_CYCLES, 16, cycles each digit is enabled
- CODE_W = $clog2(ROWS*COLS), derived, key code width

- clk  in  1  single clock
- reset  in  1  synchronous, active-low
- col  in  COLS  raw column sense, active-high, asynchronous
- row  out  ROWS  one-hot row drive, active-high
- key_valid  out  1  one-cycle pulse on accepted press
- key_code  out  CODE_W  row_idx*COLS + col_idx of last accepted key
- digit_en  out  DIGITS  one-hot digit enable, active-high; all-zero when blanked
- digit_val  out  CODE_W  code for the enabled digit

## Operation
- col passes through a 2-flop synchroniser; all logic uses col_sync.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: row one-hot on row_idx; dwell counter counts to SETTLE_CYCLES-1; on the final dwell cycle sample col_sync. Any bit set → lock row_idx and lowest set column, enter PRESS_DB. Otherwise row_idx advances, wrapping ROWS-1→0.
- PRESS_DB: row held. Locked column high for DEBOUNCE_CYCLES consecutive cycles → key_valid=1 for one cycle, key_code updated, history shifted, enter HELD. Any low cycle → SCAN, advance to next row.
- HELD: row held; other columns ignored (no multi-key, no rollover). Locked column low → RELEASE_DB.
- RELEASE_DB: locked column low DEBOUNCE_CYCLES consecutive cycles → SCAN at next row. Any high cycle → HELD; no new key_valid.
- History: on accept, hist[0]←new code, hist[i]←hist[i-1], valid[i] likewise (valid[0]←1). Oldest entry discarded.
- Display: refresh counter wraps at REFRESH_CYCLES-1, then digit_idx increments mod DIGITS. digit_en = onehot(digit_idx) if valid[digit_idx], else 0. digit_val = hist[digit_idx] (0 when invalid).

## Timing
- Reset (reset=0 at clk edge): state SCAN, row=1 (row 0), all counters 0, sync flops 0, hist=0, valid=0, key_valid=0, key_code=0, digit_idx=0, digit_en=0, digit_val=0. Reset mid-debounce discards the pending key.
- Col edge to visibility in col_sync: 2 cycles.
- key_valid asserts the cycle after the DEBOUNCE_CYCLES-th consecutive high sample; key_code and hist update on the same edge.
- digit_en/digit_val are registered; history update is visible on display outputs the next cycle.
- Scan and display counters run independently; key acceptance never stalls refresh.
- DIGITS=1: digit_idx constant 0, refresh counter still runs.

## Structure
- Package keypad_pkg: state enum (SCAN, PRESS_DB, HELD, RELEASE_DB) and CODE_W helper function.
- Sub-module digit_refresh: refresh counter, digit_idx, digit_en/digit_val muxing from hist/valid vectors.
- Synchroniser, scan FSM and history remain in the top.

## Test plan
(Defaults; SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8, REFRESH_CYCLES=16.)
- Reset, no keys → row cycles 0001,0010,0100,1000,0001 every 4 cycles; digit_en=00 throughout; key_valid never asserts.
- Hold col=0100 while row=0010 ≥20 cycles → one key_valid, key_code=6, digit_en alternates 01 (digit_val=6) and 00 every 16 cycles.
- Then press row 3/col 0 → key_code=12; digit 0 shows 12, digit 1 shows 6; digit_en alternates 01/10.
- Bounce: col high 5 cycles, low 1, high 5 → no key_valid, scan resumes at next row.
- Release bounce while held (low 3, high 2, low 10) → single key_valid total; FSM returns HELD then SCAN.
- Assert reset during PRESS_DB → row=0001, key_valid stays 0, hist/valid cleared, digit_en=00.
